// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider with duty control, run/drain and glitch-free reload
// Ports:
//   clk_in, rst_n (async active-low), en (run request)
//   period_in/high_in/load: config request, captured into a shadow on load
//   clk_out (registered divided clock), tick (pulse on each rising cycle)
//   load_pending (shadow not yet active), cfg_err (pulse on rejected load)
// Optional: CLK_DIV_SYNC_EN adds sync_in, forcing a period wrap in RUN/DRAIN.
module clk_div_prog #(
  parameter int WIDTH      = 8,
  parameter int DEF_PERIOD = 14,
  parameter int DEF_HIGH   = 7
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] period_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             load,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_in,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             load_pending,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] cnt_q, cnt_d, per_q, high_q, sh_per_q, sh_high_q;
  logic             clk_q, tick_q, pend_q, err_q, ld_ok, wrap, apply;
  assign cnt_d = cnt_q + 1'b1;
  assign ld_ok = load && period_in > WIDTH'(1) && high_in != '0 && high_in < period_in;
`ifdef CLK_DIV_SYNC_EN
  assign wrap  = cnt_q == per_q - 1'b1 || sync_in;
`else
  assign wrap  = cnt_q == per_q - 1'b1;
`endif
  // IDLE behaves like a permanent period boundary: shadow is applied and a start looks like a wrap
  assign apply = state_q == IDLE || wrap;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      per_q     <= WIDTH'(DEF_PERIOD);
      high_q    <= WIDTH'(DEF_HIGH);
      sh_per_q  <= WIDTH'(DEF_PERIOD);
      sh_high_q <= WIDTH'(DEF_HIGH);
    end else begin
      err_q <= load && !ld_ok;
      if (ld_ok) begin
        sh_per_q  <= period_in;
        sh_high_q <= high_in;
      end
      // a load landing on a boundary stays pending; the old shadow goes active this edge
      pend_q <= apply ? ld_ok : pend_q | ld_ok;
      if (apply) begin
        per_q   <= sh_per_q;
        high_q  <= sh_high_q;
        cnt_q   <= '0;
        clk_q   <= en;
        tick_q  <= en;
        state_q <= en ? RUN : IDLE;
      end else begin
        cnt_q   <= cnt_d;
        clk_q   <= cnt_d < high_q;
        tick_q  <= 1'b0;
        state_q <= en ? RUN : DRAIN;
      end
    end
  end
  assign clk_out      = clk_q;
  assign tick         = tick_q;
  assign load_pending = pend_q;
  assign cfg_err      = err_q;
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog
module tb_clk_div_prog;
  logic       clk_in = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0, sync_in = 1'b0;
  logic [7:0] period_in = '0, high_in = '0;
  logic       clk_out, tick, load_pending, cfg_err;
  int         n_cmp = 0, n_fail = 0;

  clk_div_prog dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .period_in(period_in), .high_in(high_in),
    .load(load),
`ifdef CLK_DIV_SYNC_EN
    .sync_in(sync_in),
`endif
    .clk_out(clk_out), .tick(tick), .load_pending(load_pending), .cfg_err(cfg_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; sync_in = 1'b0; period_in = '0; high_in = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({clk_out, tick, load_pending, cfg_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_outs got %b want 0000", {clk_out, tick, load_pending, cfg_err}); end
    step();
    step();
    n_cmp++; if ({clk_out, tick} !== 2'b00) begin n_fail++; $display("FAIL idle_outs got %b want 00", {clk_out, tick}); end
    en = 1'b1;
    for (int k = 0; k < 28; k++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {(k % 14) < 7, (k % 14) == 0}) begin n_fail++; $display("FAIL run_14_7 k=%0d got %b want %b", k, {clk_out, tick}, {(k % 14) < 7, (k % 14) == 0}); end
    end
  endtask

  task automatic test_reload();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {c < 7, c == 0}) begin n_fail++; $display("FAIL reload_pre c=%0d got %b want %b", c, {clk_out, tick}, {c < 7, c == 0}); end
    end
    load = 1'b1; period_in = 8'd10; high_in = 8'd3;
    step();
    load = 1'b0;
    n_cmp++; if ({load_pending, cfg_err} !== 2'b10) begin n_fail++; $display("FAIL reload_pending got %b want 10", {load_pending, cfg_err}); end
    for (int c = 5; c < 14; c++) begin
      step();
      n_cmp++; if ({clk_out, tick, load_pending} !== {c < 7, 1'b0, 1'b1}) begin n_fail++; $display("FAIL reload_finish c=%0d got %b want %b", c, {clk_out, tick, load_pending}, {c < 7, 1'b0, 1'b1}); end
    end
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++; if ({clk_out, tick, load_pending} !== {(k % 10) < 3, (k % 10) == 0, 1'b0}) begin n_fail++; $display("FAIL reload_new k=%0d got %b want %b", k, {clk_out, tick, load_pending}, {(k % 10) < 3, (k % 10) == 0, 1'b0}); end
    end
  endtask

  task automatic test_cfg_err();
    do_reset();
    en = 1'b1;
    step();
    load = 1'b1; period_in = 8'd1; high_in = 8'd1;
    step();
    n_cmp++; if ({cfg_err, load_pending} !== 2'b10) begin n_fail++; $display("FAIL err_p1h1 got %b want 10", {cfg_err, load_pending}); end
    period_in = 8'd6; high_in = 8'd6;
    step();
    n_cmp++; if ({cfg_err, load_pending} !== 2'b10) begin n_fail++; $display("FAIL err_p6h6 got %b want 10", {cfg_err, load_pending}); end
    period_in = 8'd6; high_in = 8'd0;
    step();
    n_cmp++; if ({cfg_err, load_pending} !== 2'b10) begin n_fail++; $display("FAIL err_p6h0 got %b want 10", {cfg_err, load_pending}); end
    load = 1'b0;
    step();
    n_cmp++; if ({cfg_err, load_pending} !== 2'b00) begin n_fail++; $display("FAIL err_clear got %b want 00", {cfg_err, load_pending}); end
    for (int c = 5; c < 28; c++) begin
      step();
      n_cmp++; if ({clk_out, tick, load_pending} !== {(c % 14) < 7, (c % 14) == 0, 1'b0}) begin n_fail++; $display("FAIL err_wave c=%0d got %b want %b", c, {clk_out, tick, load_pending}, {(c % 14) < 7, (c % 14) == 0, 1'b0}); end
    end
  endtask

  task automatic test_drain();
    do_reset();
    load = 1'b1; period_in = 8'd10; high_in = 8'd8;
    step();
    load = 1'b0;
    n_cmp++; if (load_pending !== 1'b1) begin n_fail++; $display("FAIL idle_load_pend got %b want 1", load_pending); end
    step();
    n_cmp++; if (load_pending !== 1'b0) begin n_fail++; $display("FAIL idle_load_apply got %b want 0", load_pending); end
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {c < 8, c == 0}) begin n_fail++; $display("FAIL drain_start c=%0d got %b want %b", c, {clk_out, tick}, {c < 8, c == 0}); end
    end
    en = 1'b0;
    for (int c = 3; c < 10; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {c < 8, 1'b0}) begin n_fail++; $display("FAIL drain_complete c=%0d got %b want %b", c, {clk_out, tick}, {c < 8, 1'b0}); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== 2'b00) begin n_fail++; $display("FAIL drain_idle i=%0d got %b want 00", i, {clk_out, tick}); end
    end
    en = 1'b1;
    step();
    n_cmp++; if ({clk_out, tick} !== 2'b11) begin n_fail++; $display("FAIL restart got %b want 11", {clk_out, tick}); end
    step();
    step();
    en = 1'b0;
    for (int c = 3; c < 10; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {c < 8, 1'b0}) begin n_fail++; $display("FAIL drain2 c=%0d got %b want %b", c, {clk_out, tick}, {c < 8, 1'b0}); end
    end
    en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {(k % 10) < 8, (k % 10) == 0}) begin n_fail++; $display("FAIL drain_resume k=%0d got %b want %b", k, {clk_out, tick}, {(k % 10) < 8, (k % 10) == 0}); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1;
    step();
    load = 1'b1; period_in = 8'd8; high_in = 8'd2;
    step();
    period_in = 8'd2; high_in = 8'd1;
    step();
    load = 1'b0;
    n_cmp++; if (load_pending !== 1'b1) begin n_fail++; $display("FAIL b2b_pend got %b want 1", load_pending); end
    for (int c = 3; c < 14; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {c < 7, 1'b0}) begin n_fail++; $display("FAIL b2b_old c=%0d got %b want %b", c, {clk_out, tick}, {c < 7, 1'b0}); end
    end
    for (int k = 0; k < 6; k++) begin
      step();
      n_cmp++; if ({clk_out, tick, load_pending} !== {(k % 2) == 0, (k % 2) == 0, 1'b0}) begin n_fail++; $display("FAIL b2b_p2 k=%0d got %b want %b", k, {clk_out, tick, load_pending}, {(k % 2) == 0, (k % 2) == 0, 1'b0}); end
    end
    load = 1'b1; period_in = 8'd5; high_in = 8'd4;
    step();
    load = 1'b0;
    n_cmp++; if ({clk_out, tick, load_pending} !== 3'b111) begin n_fail++; $display("FAIL wrap_load got %b want 111", {clk_out, tick, load_pending}); end
    step();
    n_cmp++; if ({clk_out, tick} !== 2'b00) begin n_fail++; $display("FAIL wrap_load_old got %b want 00", {clk_out, tick}); end
    step();
    n_cmp++; if ({clk_out, tick, load_pending} !== 3'b110) begin n_fail++; $display("FAIL wrap_load_apply got %b want 110", {clk_out, tick, load_pending}); end
    for (int c = 1; c < 6; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {(c % 5) < 4, (c % 5) == 0}) begin n_fail++; $display("FAIL p5h4 c=%0d got %b want %b", c, {clk_out, tick}, {(c % 5) < 4, (c % 5) == 0}); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    step();
    load = 1'b1; period_in = 8'd10; high_in = 8'd3;
    step();
    load = 1'b0;
    n_cmp++; if ({clk_out, load_pending} !== 2'b11) begin n_fail++; $display("FAIL areset_pre got %b want 11", {clk_out, load_pending}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({clk_out, tick, load_pending, cfg_err} !== 4'b0000) begin n_fail++; $display("FAIL areset_async got %b want 0000", {clk_out, tick, load_pending, cfg_err}); end
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL areset_idle got %b want 0", clk_out); end
    en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {(k % 14) < 7, (k % 14) == 0}) begin n_fail++; $display("FAIL areset_defaults k=%0d got %b want %b", k, {clk_out, tick}, {(k % 14) < 7, (k % 14) == 0}); end
    end
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 5; c++) step();
    sync_in = 1'b1;
    step();
    sync_in = 1'b0;
    n_cmp++; if ({clk_out, tick} !== 2'b11) begin n_fail++; $display("FAIL sync_wrap got %b want 11", {clk_out, tick}); end
    for (int c = 1; c < 15; c++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== {(c % 14) < 7, (c % 14) == 0}) begin n_fail++; $display("FAIL sync_after c=%0d got %b want %b", c, {clk_out, tick}, {(c % 14) < 7, (c % 14) == 0}); end
    end
    en = 1'b0;
    for (int i = 0; i < 14; i++) step();
    n_cmp++; if (clk_out !== 1'b0) begin n_fail++; $display("FAIL sync_to_idle got %b want 0", clk_out); end
    sync_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if ({clk_out, tick} !== 2'b00) begin n_fail++; $display("FAIL sync_idle i=%0d got %b want 00", i, {clk_out, tick}); end
    end
    sync_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reload();
    test_cfg_err();
    test_drain();
    test_back_to_back();
    test_async_reset();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
